// File: rtl/alu_rf_sequencer.sv
// Command-side sequencer for the ALU/register-file datapath: FIFO-buffered instructions in,
// one issue at a time, captured result/flags out. Optional macro CMP_NOWB_EN suppresses writeback for CMP_OPCODE.
module alu_rf_sequencer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [3:0]  CMP_OPCODE = 4'hB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_instr,
    output logic [3:0]        ra1,
    output logic [3:0]        ra2,
    output logic [3:0]        inst,
    output logic              regwrite,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] flagreg,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] rsp_flags
);

    localparam int unsigned ENTRY_W = 12;
    localparam int unsigned IDX_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W   = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // FIFO entries keep only the fields the datapath uses: {opcode, Rdest, Rsrc}
    logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head_c;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_c;
    logic [PTR_W-1:0]  count_d;
    logic              empty_c;
    logic              push_c;
    logic              pop_c;
    logic              nowb_c;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              regwrite_q, regwrite_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [3:0]        ra1_q, ra1_d;
    logic [3:0]        ra2_q, ra2_d;
    logic [3:0]        inst_q, inst_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [DATA_W-1:0] rsp_flags_q, rsp_flags_d;

    logic              unused_c;
    assign unused_c = ^{cmd_instr[7:4], CMP_OPCODE};

    // FIFO occupancy; cmd_ready is registered from next-cycle occupancy
    assign count_c  = wr_ptr_q - rd_ptr_q;
    assign empty_c  = (count_c == '0);
    assign push_c   = cmd_valid && cmd_ready_q;
    assign head_c   = fifo_q[rd_ptr_q[IDX_W-1:0]];
    assign wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    assign count_d  = wr_ptr_d - rd_ptr_d;
    assign cmd_ready_d = (count_d != PTR_W'(FIFO_DEPTH));

`ifdef CMP_NOWB_EN
    assign nowb_c = (inst_q == CMP_OPCODE);
`else
    assign nowb_c = 1'b0;
`endif

    // Next-state and pop decision
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WRITE;
            WRITE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs derived from the next state
    always_comb begin
        ra1_d        = ra1_q;
        ra2_d        = ra2_q;
        inst_d       = inst_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        regwrite_d   = (state_d == WRITE) && !nowb_c;
        rsp_valid_d  = (state_d == RESP);
        if (pop_c) begin
            inst_d = head_c[11:8];
            ra1_d  = head_c[7:4];
            ra2_d  = head_c[3:0];
        end
        // Operands are captured at the writeback edge, so they reflect pre-writeback state
        if (state_q == WRITE) begin
            rsp_result_d = result;
            rsp_flags_d  = flagreg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cmd_ready_q  <= 1'b1;
            regwrite_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            ra1_q        <= '0;
            ra2_q        <= '0;
            inst_q       <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cmd_ready_q  <= cmd_ready_d;
            regwrite_q   <= regwrite_d;
            rsp_valid_q  <= rsp_valid_d;
            ra1_q        <= ra1_d;
            ra2_q        <= ra2_d;
            inst_q       <= inst_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q[IDX_W-1:0]] <= {cmd_instr[15:8], cmd_instr[3:0]};
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign regwrite   = regwrite_q;
    assign rsp_valid  = rsp_valid_q;
    assign ra1        = ra1_q;
    assign ra2        = ra2_q;
    assign inst       = inst_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Bench for alu_rf_sequencer: small register-file datapath model, directed vectors and an in-order scoreboard.
module tb_alu_rf_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_instr;
    logic [3:0]  ra1, ra2, inst;
    logic        regwrite;
    logic [15:0] result, flagreg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result, rsp_flags;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rsp    = 0;
    int rw_cnt   = 0;
    int cyc      = 0;
    int last_rw  = 0;
    bit have_last = 1'b0;
    bit gap_en    = 1'b0;
    bit prev_rw   = 1'b0;
    bit rnd_mode  = 1'b0;

    logic [15:0] rf [16];
    logic [15:0] shadow [16];
    logic [15:0] exp_q [$];

    alu_rf_sequencer #(.DATA_W(16), .FIFO_DEPTH(4), .CMP_OPCODE(4'hB)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
        .ra1(ra1), .ra2(ra2), .inst(inst), .regwrite(regwrite),
        .result(result), .flagreg(flagreg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rf_init(input int i);
        return 16'(i * 32'h111 + 1);
    endfunction

    function automatic bit wb_expected(input logic [3:0] op);
`ifdef CMP_NOWB_EN
        return op != 4'hB;
`else
        return (op == op);
`endif
    endfunction

    // Datapath model: add/xor of the two read ports, writeback to ra1
    assign result  = rf[ra1] + rf[ra2];
    assign flagreg = rf[ra1] ^ rf[ra2];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_init(i);
        end else if (regwrite) begin
            rf[ra1] <= result;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic shadow_reset();
        for (int i = 0; i < 16; i++) shadow[i] = rf_init(i);
    endtask

    task automatic tick();
        @(negedge clk);
        if (rnd_mode) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [15:0] w);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_instr = w;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("push_timeout", 32'(cmd_ready), 32'd1);
        else exp_q.push_back(w);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 3000) begin
            tick();
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_q.delete();
        shadow_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Response scoreboard and regwrite pulse monitor
    initial begin
        logic [15:0] w, er, ef;
        forever begin
            @(negedge clk);
            #1;
            if (regwrite) begin
                rw_cnt++;
                check("rw_width", 32'(prev_rw), 32'd0);
                if (gap_en && have_last) check("rw_gap", 32'(cyc - last_rw), 32'd3);
                last_rw   = cyc;
                have_last = 1'b1;
            end
            prev_rw = regwrite;
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    w  = exp_q.pop_front();
                    er = shadow[w[11:8]] + shadow[w[3:0]];
                    ef = shadow[w[11:8]] ^ shadow[w[3:0]];
                    check("rsp_result", 32'(rsp_result), 32'(er));
                    check("rsp_flags", 32'(rsp_flags), 32'(ef));
                    if (wb_expected(w[15:12])) shadow[w[11:8]] = er;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int rw_before;
        reset = 1'b1; cmd_valid = 1'b0; cmd_instr = '0; rsp_ready = 1'b0;
        shadow_reset();
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_ra1", 32'(ra1), 32'd0);
        check("rst_ra2", 32'(ra2), 32'd0);
        check("rst_inst", 32'(inst), 32'd0);
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);

        // Single instruction latency and decode
        push(16'h5102);
        tick();
        check("t1_ra1", 32'(ra1), 32'd1);
        check("t1_ra2", 32'(ra2), 32'd2);
        check("t1_inst", 32'(inst), 32'd5);
        check("t1_issue_rw", 32'(regwrite), 32'd0);
        check("t1_issue_rv", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_write_rw", 32'(regwrite), 32'd1);
        check("t1_write_rv", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_resp_rw", 32'(regwrite), 32'd0);
        check("t1_resp_rv", 32'(rsp_valid), 32'd1);
        check("t1_result", 32'(rsp_result), 32'h335);
        check("t1_flags", 32'(rsp_flags), 32'h331);
        rsp_ready = 1'b1;
        tick();
        check("t1_rv_drop", 32'(rsp_valid), 32'd0);
        drain();
        check("t1_rsp_count", 32'(n_rsp), 32'd1);

        // Back-to-back stream, 3 cycles per instruction
        have_last = 1'b0;
        gap_en    = 1'b1;
        push(16'h1304);
        push(16'h2405);
        push(16'h3506);
        push(16'h4607);
        drain();
        gap_en = 1'b0;
        check("t2_rsp_count", 32'(n_rsp), 32'd5);

        // Backpressure: response held, FIFO fills
        do_reset();
        push(16'h2607);
        wait_rsp_valid();
        push(16'h1102);
        push(16'h3201);
        push(16'h4303);
        push(16'h6A48);
        check("t3_full", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_rv", 32'(rsp_valid), 32'd1);
            check("t3_result", 32'(rsp_result), 32'hDDF);
            check("t3_flags", 32'(rsp_flags), 32'h11F);
            check("t3_rw", 32'(regwrite), 32'd0);
            check("t3_nopop", 32'(cmd_ready), 32'd0);
            check("t3_ra1", 32'(ra1), 32'd6);
        end
        rsp_ready = 1'b1;
        drain();
        check("t3_rsp_count", 32'(n_rsp), 32'd10);

        // Reset during WRITE with three words queued
        rsp_ready = 1'b0;
        push(16'h7A0B);
        wait_rsp_valid();
        push(16'h1C0D);
        push(16'h2E0F);
        push(16'h3102);
        push(16'h4203);
        rsp_ready = 1'b1;
        n = 0;
        while (!regwrite && n < 20) begin
            tick();
            n++;
        end
        check("t4_rw_seen", 32'(regwrite), 32'd1);
        reset     = 1'b1;
        rsp_ready = 1'b0;
        exp_q.delete();
        shadow_reset();
        tick();
        check("t4_rw", 32'(regwrite), 32'd0);
        check("t4_rv", 32'(rsp_valid), 32'd0);
        check("t4_cmd_ready", 32'(cmd_ready), 32'd1);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) tick();
        check("t4_rv_idle", 32'(rsp_valid), 32'd0);
        check("t4_rsp_count", 32'(n_rsp), 32'd11);

        // Pointer wrap under random response backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 20; i++) push(16'($urandom));
        drain();
        rnd_mode  = 1'b0;
        rsp_ready = 1'b0;
        check("t5_rsp_count", 32'(n_rsp), 32'd31);

        // Compare opcode: writeback depends on CMP_NOWB_EN
        do_reset();
        rw_before = rw_cnt;
        push(16'hB304);
        wait_rsp_valid();
        check("t6_result", 32'(rsp_result), 32'h779);
        check("t6_flags", 32'(rsp_flags), 32'h771);
        rsp_ready = 1'b1;
        drain();
`ifdef CMP_NOWB_EN
        check("t6_rw_count", 32'(rw_cnt - rw_before), 32'd0);
`else
        check("t6_rw_count", 32'(rw_cnt - rw_before), 32'd1);
`endif
        check("t6_rsp_count", 32'(n_rsp), 32'd32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
